// File: rtl/exp6_fluxo_dados_if.sv
// Control/status bundle between the exp6 control FSM (master) and its datapath (slave).
interface exp6_fluxo_dados_if;
  logic       zeraCR;
  logic       contaCR;
  logic       zeraE;
  logic       contaE;
  logic       limpaRC;
  logic       registraRC;
  logic       zeraLeds;
  logic       registraLeds;
  logic       contaT;
  logic [3:0] botoes;
  logic       led_selector;

  logic       jogada_correta;
  logic       enderecoIgualRodada;
  logic       fimC;
  logic       fimL;
  logic       jogada_feita;
  logic       db_tem_jogada;
  logic       timeout;
  logic [3:0] db_contagem;
  logic [3:0] db_memoria;
  logic [3:0] db_jogada;
  logic [3:0] db_rodada;
  logic [3:0] leds;

  modport master (
    output zeraCR, contaCR, zeraE, contaE, limpaRC, registraRC,
           zeraLeds, registraLeds, contaT, botoes, led_selector,
    input  jogada_correta, enderecoIgualRodada, fimC, fimL, jogada_feita,
           db_tem_jogada, timeout, db_contagem, db_memoria, db_jogada,
           db_rodada, leds
  );

  modport slave (
    input  zeraCR, contaCR, zeraE, contaE, limpaRC, registraRC,
           zeraLeds, registraLeds, contaT, botoes, led_selector,
    output jogada_correta, enderecoIgualRodada, fimC, fimL, jogada_feita,
           db_tem_jogada, timeout, db_contagem, db_memoria, db_jogada,
           db_rodada, leds
  );
endinterface

// File: rtl/exp6_fluxo_dados.sv
// Datapath of the exp6 sequence-memory game: counters, sequence ROM, play/LED registers,
// button edge detector and play timeout. Define TIMEOUT_EN to build the timeout timer.
module exp6_fluxo_dados #(
  parameter int unsigned TIMEOUT_CYCLES = 3000
) (
  input logic               clock,
  input logic               reset,
  exp6_fluxo_dados_if.slave bus
);

  logic [3:0] cr;
  logic [3:0] e;
  logic [3:0] rc;
  logic [3:0] led_reg;
  logic [3:0] rom_data;
  logic [3:0] led_mux;
  logic       p_now;
  logic       p_prev;

  // Round counter
  always_ff @(posedge clock) begin
    if (reset)            cr <= '0;
    else if (bus.zeraCR)  cr <= '0;
    else if (bus.contaCR) cr <= cr + 4'd1;
  end

  // Address / play counter
  always_ff @(posedge clock) begin
    if (reset)           e <= '0;
    else if (bus.zeraE)  e <= '0;
    else if (bus.contaE) e <= e + 4'd1;
  end

  // Play register
  always_ff @(posedge clock) begin
    if (reset)               rc <= '0;
    else if (bus.limpaRC)    rc <= '0;
    else if (bus.registraRC) rc <= bus.botoes;
  end

  // Sequence ROM, asynchronous read
  always_comb begin
    rom_data = 4'b0001;
    case (e)
      4'h0: rom_data = 4'b0001;
      4'h1: rom_data = 4'b0010;
      4'h2: rom_data = 4'b0100;
      4'h3: rom_data = 4'b1000;
      4'h4: rom_data = 4'b0100;
      4'h5: rom_data = 4'b0010;
      4'h6: rom_data = 4'b0001;
      4'h7: rom_data = 4'b0001;
      4'h8: rom_data = 4'b0010;
      4'h9: rom_data = 4'b0010;
      4'hA: rom_data = 4'b0100;
      4'hB: rom_data = 4'b0100;
      4'hC: rom_data = 4'b1000;
      4'hD: rom_data = 4'b1000;
      4'hE: rom_data = 4'b0001;
      4'hF: rom_data = 4'b0100;
      default: rom_data = 4'b0001;
    endcase
  end

  // LED register fed by ROM data or the raw buttons
  assign led_mux = bus.led_selector ? rom_data : bus.botoes;

  always_ff @(posedge clock) begin
    if (reset)                 led_reg <= '0;
    else if (bus.zeraLeds)     led_reg <= '0;
    else if (bus.registraLeds) led_reg <= led_mux;
  end

  // Button press detector: pulse only on the idle -> pressed transition
  assign p_now = |bus.botoes;

  always_ff @(posedge clock) begin
    if (reset) p_prev <= 1'b0;
    else       p_prev <= p_now;
  end

`ifdef TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] t_cnt;

  // Saturates at the last count so timeout stays asserted while contaT is held
  always_ff @(posedge clock) begin
    if (reset)                t_cnt <= '0;
    else if (!bus.contaT)     t_cnt <= '0;
    else if (t_cnt != T_LAST) t_cnt <= t_cnt + TW'(1);
  end

  assign bus.timeout = bus.contaT && (t_cnt == T_LAST);
`else
  logic unused_contat;
  assign unused_contat = bus.contaT;
  assign bus.timeout   = 1'b0;
`endif

  assign bus.jogada_correta      = (rom_data == rc);
  assign bus.enderecoIgualRodada = (e == cr);
  assign bus.fimC                = (e == 4'hF);
  assign bus.fimL                = (cr == 4'hF);
  assign bus.jogada_feita        = p_now & ~p_prev;
  assign bus.db_tem_jogada       = p_now;
  assign bus.db_contagem         = e;
  assign bus.db_memoria          = rom_data;
  assign bus.db_jogada           = rc;
  assign bus.db_rodada           = cr;
  assign bus.leds                = led_reg;

endmodule

// File: tb/tb_exp6_fluxo_dados.sv
// Directed self-checking bench for the exp6 datapath.
module tb_exp6_fluxo_dados;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  exp6_fluxo_dados_if bus ();

  exp6_fluxo_dados #(.TIMEOUT_CYCLES(3000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_controls();
    bus.zeraCR = 0; bus.contaCR = 0; bus.zeraE = 0; bus.contaE = 0;
    bus.limpaRC = 0; bus.registraRC = 0; bus.zeraLeds = 0; bus.registraLeds = 0;
    bus.contaT = 0; bus.botoes = 4'b0000; bus.led_selector = 0;
  endtask

  task automatic test_reset();
    idle_controls();
    reset = 1;
    tick();
    reset = 0;
    #1;
    checks++; if (bus.db_rodada !== 4'h0) begin errors++; $display("FAIL reset_rodada got %h exp 0", bus.db_rodada); end
    checks++; if (bus.db_contagem !== 4'h0) begin errors++; $display("FAIL reset_contagem got %h exp 0", bus.db_contagem); end
    checks++; if (bus.leds !== 4'h0) begin errors++; $display("FAIL reset_leds got %b exp 0000", bus.leds); end
    checks++; if (bus.db_jogada !== 4'h0) begin errors++; $display("FAIL reset_jogada got %b exp 0000", bus.db_jogada); end
    checks++; if (bus.enderecoIgualRodada !== 1'b1) begin errors++; $display("FAIL reset_eir got %b exp 1", bus.enderecoIgualRodada); end
    checks++; if (bus.db_memoria !== 4'b0001) begin errors++; $display("FAIL reset_memoria got %b exp 0001", bus.db_memoria); end
    checks++; if (bus.jogada_correta !== 1'b0) begin errors++; $display("FAIL reset_correta got %b exp 0", bus.jogada_correta); end
    checks++; if ({bus.fimC, bus.fimL, bus.jogada_feita, bus.timeout} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {bus.fimC, bus.fimL, bus.jogada_feita, bus.timeout}); end
  endtask

  task automatic test_first_play();
    bus.botoes = 4'b0001;
    #1;
    checks++; if (bus.jogada_feita !== 1'b1) begin errors++; $display("FAIL press_pulse got %b exp 1", bus.jogada_feita); end
    checks++; if (bus.db_tem_jogada !== 1'b1) begin errors++; $display("FAIL tem_jogada got %b exp 1", bus.db_tem_jogada); end
    tick();
    checks++; if (bus.jogada_feita !== 1'b0) begin errors++; $display("FAIL press_one_cycle got %b exp 0", bus.jogada_feita); end
    bus.registraRC = 1;
    tick();
    bus.registraRC = 0;
    #1;
    checks++; if (bus.db_jogada !== 4'b0001) begin errors++; $display("FAIL load_rc got %b exp 0001", bus.db_jogada); end
    checks++; if (bus.jogada_correta !== 1'b1) begin errors++; $display("FAIL correct_play got %b exp 1", bus.jogada_correta); end
    tick();
    checks++; if (bus.jogada_feita !== 1'b0) begin errors++; $display("FAIL held_no_pulse got %b exp 0", bus.jogada_feita); end
    bus.botoes = 4'b0000;
    tick();
    checks++; if (bus.db_tem_jogada !== 1'b0) begin errors++; $display("FAIL tem_jogada_off got %b exp 0", bus.db_tem_jogada); end
    bus.botoes = 4'b0100;
    tick();
    bus.botoes = 4'b0010;
    #1;
    checks++; if (bus.jogada_feita !== 1'b0) begin errors++; $display("FAIL change_no_pulse got %b exp 0", bus.jogada_feita); end
    bus.botoes = 4'b0000;
    tick();
  endtask

  task automatic test_wrong_play();
    bus.contaE = 1;
    tick();
    bus.contaE = 0;
    #1;
    checks++; if (bus.db_contagem !== 4'h1) begin errors++; $display("FAIL e_inc got %h exp 1", bus.db_contagem); end
    checks++; if (bus.db_memoria !== 4'b0010) begin errors++; $display("FAIL rom1 got %b exp 0010", bus.db_memoria); end
    checks++; if (bus.enderecoIgualRodada !== 1'b0) begin errors++; $display("FAIL eir_ne got %b exp 0", bus.enderecoIgualRodada); end
    bus.botoes = 4'b0001;
    bus.registraRC = 1;
    tick();
    bus.registraRC = 0;
    bus.botoes = 4'b0000;
    #1;
    checks++; if (bus.jogada_correta !== 1'b0) begin errors++; $display("FAIL wrong_play got %b exp 0", bus.jogada_correta); end
    bus.limpaRC = 1;
    bus.registraRC = 1;
    bus.botoes = 4'b1000;
    tick();
    bus.limpaRC = 0; bus.registraRC = 0; bus.botoes = 4'b0000;
    #1;
    checks++; if (bus.db_jogada !== 4'b0000) begin errors++; $display("FAIL limpa_rc got %b exp 0000", bus.db_jogada); end
    bus.zeraE = 1;
    tick();
    bus.zeraE = 0;
    tick();
  endtask

  task automatic test_counters();
    bus.contaCR = 1;
    repeat (15) tick();
    bus.contaCR = 0;
    #1;
    checks++; if (bus.db_rodada !== 4'hF) begin errors++; $display("FAIL cr15 got %h exp f", bus.db_rodada); end
    checks++; if (bus.fimL !== 1'b1) begin errors++; $display("FAIL fimL got %b exp 1", bus.fimL); end
    bus.contaCR = 1;
    tick();
    bus.contaCR = 0;
    #1;
    checks++; if (bus.db_rodada !== 4'h0) begin errors++; $display("FAIL cr_wrap got %h exp 0", bus.db_rodada); end
    bus.contaCR = 1;
    repeat (2) tick();
    bus.contaCR = 0;
    bus.contaE = 1;
    tick();
    bus.contaE = 0;
    #1;
    checks++; if (bus.enderecoIgualRodada !== 1'b0) begin errors++; $display("FAIL eir_e1 got %b exp 0", bus.enderecoIgualRodada); end
    bus.contaE = 1;
    tick();
    bus.contaE = 0;
    #1;
    checks++; if (bus.enderecoIgualRodada !== 1'b1) begin errors++; $display("FAIL eir_e2 got %b exp 1", bus.enderecoIgualRodada); end
    bus.zeraE = 1;
    bus.contaE = 1;
    tick();
    bus.zeraE = 0;
    bus.contaE = 0;
    #1;
    checks++; if (bus.db_contagem !== 4'h0) begin errors++; $display("FAIL zeraE_prio got %h exp 0", bus.db_contagem); end
    bus.contaE = 1;
    repeat (15) tick();
    bus.contaE = 0;
    #1;
    checks++; if (bus.fimC !== 1'b1) begin errors++; $display("FAIL fimC got %b exp 1", bus.fimC); end
    checks++; if (bus.db_memoria !== 4'b0100) begin errors++; $display("FAIL rom15 got %b exp 0100", bus.db_memoria); end
    bus.contaE = 1;
    tick();
    bus.contaE = 0;
    #1;
    checks++; if (bus.db_contagem !== 4'h0 || bus.fimC !== 1'b0) begin errors++; $display("FAIL e_wrap got %h/%b exp 0/0", bus.db_contagem, bus.fimC); end
    bus.zeraCR = 1;
    bus.contaCR = 1;
    tick();
    bus.zeraCR = 0;
    bus.contaCR = 0;
    #1;
    checks++; if (bus.db_rodada !== 4'h0) begin errors++; $display("FAIL zeraCR_prio got %h exp 0", bus.db_rodada); end
  endtask

  task automatic test_leds();
    bus.contaE = 1;
    repeat (3) tick();
    bus.contaE = 0;
    bus.led_selector = 1;
    bus.registraLeds = 1;
    tick();
    bus.registraLeds = 0;
    #1;
    checks++; if (bus.leds !== 4'b1000) begin errors++; $display("FAIL leds_rom got %b exp 1000", bus.leds); end
    bus.led_selector = 0;
    bus.botoes = 4'b0100;
    bus.registraLeds = 1;
    tick();
    bus.registraLeds = 0;
    #1;
    checks++; if (bus.leds !== 4'b0100) begin errors++; $display("FAIL leds_btn got %b exp 0100", bus.leds); end
    bus.zeraLeds = 1;
    bus.registraLeds = 1;
    tick();
    bus.zeraLeds = 0;
    bus.registraLeds = 0;
    bus.botoes = 4'b0000;
    #1;
    checks++; if (bus.leds !== 4'b0000) begin errors++; $display("FAIL leds_clear got %b exp 0000", bus.leds); end
  endtask

  task automatic test_timeout();
`ifdef TIMEOUT_EN
    bus.contaT = 1;
    repeat (50) tick();
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_50 got %b exp 0", bus.timeout); end
    bus.contaT = 0;
    tick();
    bus.contaT = 1;
    repeat (2998) tick();
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_2999th got %b exp 0", bus.timeout); end
    tick();
    checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL to_3000th got %b exp 1", bus.timeout); end
    repeat (5) tick();
    checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL to_hold got %b exp 1", bus.timeout); end
    bus.contaT = 0;
    #1;
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_drop got %b exp 0", bus.timeout); end
    tick();
    bus.contaT = 1;
    repeat (2998) tick();
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_restart got %b exp 0", bus.timeout); end
    tick();
    checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL to_restart_end got %b exp 1", bus.timeout); end
    bus.contaT = 0;
    tick();
`else
    bus.contaT = 1;
    repeat (3100) tick();
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_disabled got %b exp 0", bus.timeout); end
    bus.contaT = 0;
    tick();
`endif
  endtask

  task automatic test_reset_priority();
    bus.contaCR = 1; bus.contaE = 1; bus.registraRC = 1; bus.registraLeds = 1;
    bus.botoes = 4'b1111; bus.contaT = 1;
    repeat (3) tick();
    reset = 1;
    tick();
    reset = 0;
    idle_controls();
    #1;
    checks++; if ({bus.db_rodada, bus.db_contagem, bus.db_jogada, bus.leds} !== 16'h0000) begin errors++; $display("FAIL reset_prio got %h exp 0000", {bus.db_rodada, bus.db_contagem, bus.db_jogada, bus.leds}); end
    checks++; if (bus.jogada_feita !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_prio_flags got %b%b exp 00", bus.jogada_feita, bus.timeout); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 0;
    idle_controls();
    test_reset();
    test_first_play();
    test_wrong_play();
    test_counters();
    test_leds();
    test_timeout();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp6_fluxo_dados.md
Name: exp6_fluxo_dados

Overview:
Datapath of the sequence-memory game (exp6) and is driven by the exp6 control FSM. It contains:
- round counter (CR) and address/play counter (E)
- 16x4 sequence ROM
- play register (RC) and LED register
- button edge detector and play timeout timer
The FSM reads the datapath's status flags and debug outputs.

Parameters:
TIMEOUT_CYCLES, 3000, cycles contaT must stay asserted before timeout asserts (3 s at 1 kHz).

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous active-high reset, clears all internal state
zeraCR  in  1  sync clear of round counter
contaCR  in  1  increment round counter
zeraE  in  1  sync clear of address counter
contaE  in  1  increment address counter
limpaRC  in  1  sync clear of play register
registraRC  in  1  load botoes into play register
zeraLeds  in  1  sync clear of LED register
registraLeds  in  1  load LED register from LED mux
contaT  in  1  timeout timer enable
botoes  in  4  player buttons, one-hot in normal use
led_selector  in  1  LED mux select: 1 = ROM data, 0 = botoes
jogada_correta  out  1  ROM data equals play register
enderecoIgualRodada  out  1  address counter equals round counter
fimC  out  1  address counter == 15
fimL  out  1  round counter == 15
jogada_feita  out  1  one-cycle pulse on a new button press
db_tem_jogada  out  1  OR of botoes, combinational
timeout  out  1  timer reached TIMEOUT_CYCLES-1 while enabled
db_contagem  out  4  address counter value
db_memoria  out  4  ROM data at current address
db_jogada  out  4  play register value
db_rodada  out  4  round counter value
leds  out  4  LED register value

Behaviour:
- Reset: on reset=1 at a clock edge, the following clear to 0: CR, E, RC, LED register, timer, edge-detector history. All outputs then follow combinationally: jogada_correta=(ROM[0]==0)=0, enderecoIgualRodada=1, fimC=0, fimL=0, jogada_feita=0, timeout=0.
- Reset priority: reset overrides every control input.
- Counters CR and E:
  - 4-bit, modulo 16; 15 increments to 0.
  - Clear (zeraX) has priority over count (contaX).
  - Change occurs at the clock edge where the control is sampled high.
- Play register RC:
  - limpaRC has priority; registraRC loads botoes.
  - Otherwise holds its value.
- ROM:
  - 16x4, asynchronous read, addressed by E; db_memoria = ROM[E].
  - Contents, addr 0..15: 0001,0010,0100,1000,0100,0010,0001,0001,0010,0010,0100,0100,1000,1000,0001,0100.
- Comparators (combinational):
  - jogada_correta = (ROM[E] == RC)
  - enderecoIgualRodada = (E == CR)
  - fimC = (E == 4'hF)
  - fimL = (CR == 4'hF)
- LED register:
  - zeraLeds has priority.
  - registraLeds loads led_selector ? ROM[E] : botoes.
  - leds = register output.
- Edge detector:
  - p = |botoes is registered each cycle.
  - jogada_feita = p & ~p_registered: exactly one cycle high per 0→nonzero transition of botoes.
  - A held button gives a single pulse.
  - Changing from one nonzero value to another nonzero value gives no pulse.
- db_tem_jogada = |botoes, no delay.
- Timer:
  - Counter of ceil(log2(TIMEOUT_CYCLES)) bits.
  - Increments while contaT=1; cleared synchronously whenever contaT=0.
  - timeout = contaT & (count == TIMEOUT_CYCLES-1).
  - At TIMEOUT_CYCLES-1 the counter holds, so timeout stays high while contaT remains high.
- Simultaneous clear+count on the same counter: clear wins.
- No other side effects.

Optional Feature:
TIMEOUT_EN.
- Defined: timer and timeout behave as above.
- Undefined: timer is not instantiated, timeout is tied to 0, and contaT is ignored.

Test Plan:
- Reset: reset=1 for 1 cycle, then controls low, botoes=0 → db_rodada=0, db_contagem=0, leds=0, enderecoIgualRodada=1, db_memoria=0001, timeout=0.
- Correct first play: botoes 0000→0001 → jogada_feita high exactly 1 cycle. Then registraRC=1 for 1 cycle → db_jogada=0001, jogada_correta=1. Held button gives no second pulse.
- Wrong play: with E=1 (ROM=0010), load botoes=0001 via registraRC → jogada_correta=0.
- Counters: contaCR for 15 cycles → fimL=1, db_rodada=F; one more contaCR → 0.
  - contaE with CR=2 → enderecoIgualRodada=1 after 2 increments.
  - zeraE+contaE together → E=0.
- LEDs:
  - led_selector=1, registraLeds=1 at E=3 → leds=1000.
  - led_selector=0, botoes=0100, registraLeds=1 → leds=0100.
  - zeraLeds → 0000.
- Timeout (TIMEOUT_EN defined, TIMEOUT_CYCLES=3000):
  - contaT high 50 cycles → timeout=0.
  - contaT high 3000 cycles → timeout=1 on the 3000th cycle.
  - contaT low for 1 cycle → timeout=0 and timer restarts from 0.
